// File: rtl/uart_value_reporter_pkg.sv
// Shared types and constants for the UART value reporter and its BCD converter.
package uart_report_pkg;

  // One-hot report sequencer states
  typedef enum logic [6:0] {
    ST_IDLE    = 7'b000_0001,
    ST_CONV    = 7'b000_0010,
    ST_PACK    = 7'b000_0100,
    ST_SEND    = 7'b000_1000,
    ST_WAIT_HI = 7'b001_0000,
    ST_WAIT_LO = 7'b010_0000,
    ST_DONE    = 7'b100_0000
  } state_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_EQ   = 8'h3D;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  localparam int MAX_DIGITS      = 10;
  localparam int MAX_FRAME_BYTES = 14;
  localparam int BIN_BITS        = 32;
  localparam int BCD_BITS        = 4 * MAX_DIGITS;

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more
  function automatic logic [BCD_BITS-1:0] bcd_adjust(input logic [BCD_BITS-1:0] b);
    logic [BCD_BITS-1:0] r;
    r = b;
    for (int unsigned n = 0; n < MAX_DIGITS; n++) begin
      if (b[4*n +: 4] >= 4'd5) begin
        r[4*n +: 4] = b[4*n +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_value_reporter_if.sv
// Request / framer bundle between a report requester, the reporter and the UART framer.
interface uart_value_reporter_if #(
  parameter int STR_BITS = 1096
);
  logic                rpt_req;
  logic [7:0]          rpt_tag;
  logic [31:0]         rpt_value;
  logic                rpt_busy;
  logic                rpt_done;
  logic                rpt_err;
  logic [STR_BITS-1:0] tx_string;
  logic [7:0]          tx_length;
  logic                tx_req;
  logic                tx_busy;

  // Requester and framer side
  modport master (
    output rpt_req, rpt_tag, rpt_value, tx_busy,
    input  rpt_busy, rpt_done, rpt_err, tx_string, tx_length, tx_req
  );

  // Reporter side
  modport slave (
    input  rpt_req, rpt_tag, rpt_value, tx_busy,
    output rpt_busy, rpt_done, rpt_err, tx_string, tx_length, tx_req
  );
endinterface

// File: rtl/uart_value_reporter_bin2bcd_seq.sv
// Iterative double-dabble: 32-bit binary to 10-digit BCD in 32 clock cycles.
module bin2bcd_seq
  import uart_report_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                start,
  input  logic [BIN_BITS-1:0] bin,
  output logic [BCD_BITS-1:0] bcd,
  output logic                done
);

  logic [BCD_BITS-1:0] r_bcd;
  logic [BIN_BITS-1:0] r_bin;
  logic [4:0]          r_cnt;
  logic                r_run;
  logic [BCD_BITS-1:0] w_adj;

  assign w_adj = bcd_adjust(r_bcd);
  assign bcd   = r_bcd;
  // Final shift happens on the edge that ends the cycle where done is high
  assign done  = r_run && (r_cnt == 5'd31);

  // Load on start, then one adjust-and-shift of the 72-bit {bcd,bin} pair per cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bcd <= '0;
      r_bin <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (start) begin
      r_bcd <= '0;
      r_bin <= bin;
      r_cnt <= '0;
      r_run <= 1'b1;
    end else if (r_run) begin
      {r_bcd, r_bin} <= {w_adj[BCD_BITS-2:0], r_bin, 1'b0};
      r_cnt          <= r_cnt + 5'd1;
      if (r_cnt == 5'd31) begin
        r_run <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_value_reporter.sv
// Formats a tagged 32-bit value as "<tag>=<decimal>\r\n", hands it to the UART
// framer and follows the framer's busy flag until the frame has been sent.
module uart_value_reporter
  import uart_report_pkg::*;
#(
  parameter int STR_BITS    = 1096,
  parameter int TIMEOUT_CYC = 16
) (
  input logic                 sys_clk,
  input logic                 sys_rst_n,
  uart_value_reporter_if.slave bus
);

  localparam int FRAME_BITS = 8 * MAX_FRAME_BYTES;
  localparam int TMO_W      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  state_t                r_state;
  state_t                w_next;
  logic                  w_conv_start;
  logic                  w_conv_done;
  logic [BCD_BITS-1:0]   w_bcd;
  logic [7:0]            r_tag;
  logic [FRAME_BITS-1:0] r_frame;
  logic [7:0]            r_len;
  logic [3:0]            r_ndig;
  logic [3:0]            r_pidx;
  logic                  r_started;
  logic [TMO_W-1:0]      r_tmo;
  logic                  r_err;
  logic [3:0]            w_nib;
  logic                  w_emit;

  bin2bcd_seq u_b2b (
    .i_clk   (sys_clk),
    .i_rst_n (sys_rst_n),
    .start   (w_conv_start),
    .bin     (bus.rpt_value),
    .bcd     (w_bcd),
    .done    (w_conv_done)
  );

  assign w_nib  = w_bcd[{r_pidx, 2'b00} +: 4];
  assign w_emit = (w_nib != 4'd0) || r_started || (r_pidx == 4'd0);

  assign bus.tx_string = STR_BITS'(r_frame);
  assign bus.tx_length = r_len;
  assign bus.rpt_err   = r_err;

  // State register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (bus.rpt_req) w_next = ST_CONV;
      ST_CONV:    if (w_conv_done) w_next = ST_PACK;
      ST_PACK:    if (r_pidx == 4'd0) w_next = ST_SEND;
      ST_SEND:    w_next = ST_WAIT_HI;
      ST_WAIT_HI: begin
        if (bus.tx_busy) begin
          w_next = ST_WAIT_LO;
        end else if (r_tmo == TMO_LAST) begin
          w_next = ST_DONE;
        end
      end
      ST_WAIT_LO: if (!bus.tx_busy) w_next = ST_DONE;
      ST_DONE:    w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    bus.rpt_busy = (r_state != ST_IDLE);
    bus.rpt_done = (r_state == ST_DONE);
    bus.tx_req   = (r_state == ST_SEND);
    w_conv_start = (r_state == ST_IDLE) && bus.rpt_req;
  end

  // Datapath: latch request, build the frame during PACK, run the busy timeout
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_tag     <= '0;
      r_frame   <= '0;
      r_len     <= '0;
      r_ndig    <= '0;
      r_pidx    <= '0;
      r_started <= 1'b0;
      r_tmo     <= '0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.rpt_req) begin
            r_tag     <= bus.rpt_tag;
            r_frame   <= '0;
            r_len     <= '0;
            r_err     <= 1'b0;
            r_ndig    <= '0;
            r_started <= 1'b0;
            r_pidx    <= 4'(MAX_DIGITS - 1);
          end
        end
        ST_PACK: begin
          if (w_emit) begin
            r_frame[8*(int'(r_ndig)+2) +: 8] <= ASCII_ZERO + {4'd0, w_nib};
            r_ndig    <= r_ndig + 4'd1;
            r_started <= 1'b1;
          end
          if (r_pidx == 4'd0) begin
            // The units digit is always emitted this cycle, so CR/LF sit one
            // and two bytes past it and the length counts that digit too.
            r_frame[7:0]                     <= r_tag;
            r_frame[15:8]                    <= ASCII_EQ;
            r_frame[8*(int'(r_ndig)+3) +: 8] <= ASCII_CR;
            r_frame[8*(int'(r_ndig)+4) +: 8] <= ASCII_LF;
            r_len <= 8'(r_ndig) + 8'd5;
          end else begin
            r_pidx <= r_pidx - 4'd1;
          end
        end
        ST_SEND: begin
          r_tmo <= '0;
        end
        ST_WAIT_HI: begin
          if (!bus.tx_busy) begin
            if (r_tmo == TMO_LAST) begin
              r_err <= 1'b1;
            end else begin
              r_tmo <= r_tmo + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_value_reporter.sv
// Self-checking bench for uart_value_reporter: a cycle-level model derived from
// the report timing and text format, plus literal checks on selected results.
module tb_uart_value_reporter;

  localparam int STR_BITS = 1096;
  localparam int TMO      = 16;
  localparam int FB       = 112;
  localparam int REQ_K    = 1 + 32 + 10;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;

  uart_value_reporter_if #(.STR_BITS(STR_BITS)) bus ();

  uart_value_reporter #(
    .STR_BITS    (STR_BITS),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Model state
  bit    m_active  = 1'b0;
  int    m_base    = 0;
  int    m_done_k  = 0;
  bit    m_err     = 1'b0;
  bit    m_vis_err = 1'b0;
  string m_str     = "";
  string m_vis     = "";

  int n_cmp   = 0;
  int n_bad   = 0;
  int n_txreq = 0;
  int r_req_k;
  int r_done_k;
  bit r_done_err;
  bit chk_en  = 1'b0;
  bit fr_en   = 1'b0;
  int fr_len  = 1;
  int txreq0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_vec(input string nm, input logic [FB-1:0] act, input logic [FB-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_frame(input string nm, input string s);
    logic [FB-1:0] e;
    logic          hi_nz;
    e = '0;
    for (int i = 0; i < s.len(); i++) e[8*i +: 8] = s[i];
    hi_nz = |bus.tx_string[STR_BITS-1:FB];
    n_cmp++;
    if (bus.tx_string[FB-1:0] !== e || hi_nz !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: got %h (upper nonzero=%0b), expected %h (t=%0t)",
               nm, bus.tx_string[FB-1:0], hi_nz, e, $time);
    end
  endtask

  // Framer: busy rises the cycle after tx_req and stays high fr_len cycles
  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (bus.tx_req && fr_en) begin
        @(posedge sys_clk);
        #1 bus.tx_busy = 1'b1;
        repeat (fr_len) @(posedge sys_clk);
        #1 bus.tx_busy = 1'b0;
      end
    end
  end

  // Compare process: every cycle, DUT against the report model
  initial begin
    int k;
    forever begin
      @(negedge sys_clk);
      if (chk_en) begin
        if (bus.tx_req) n_txreq++;
        k = cyc - m_base;
        if (m_active && k > m_done_k) begin
          m_active  = 1'b0;
          m_vis     = m_str;
          m_vis_err = m_err;
        end
        if (m_active && k >= 1) begin
          chk("rpt_busy", bus.rpt_busy, 1);
          chk("rpt_done", bus.rpt_done, (k == m_done_k));
          chk("tx_req", bus.tx_req, (k == REQ_K));
          if (k == m_done_k) chk("rpt_err", bus.rpt_err, m_err);
          if (k <= 32) chk_frame("string_cleared", "");
          if (k >= REQ_K) begin
            chk_frame("tx_string", m_str);
            chk("tx_length", bus.tx_length, m_str.len());
          end
          if (bus.tx_req) r_req_k = k;
          if (bus.rpt_done) begin
            r_done_k   = k;
            r_done_err = bus.rpt_err;
          end
        end else begin
          chk("idle_busy", bus.rpt_busy, 0);
          chk("idle_done", bus.rpt_done, 0);
          chk("idle_tx_req", bus.tx_req, 0);
          chk("idle_err", bus.rpt_err, m_vis_err);
          chk_frame("idle_string", m_vis);
          chk("idle_length", bus.tx_length, m_vis.len());
        end
      end
    end
  end

  task automatic run_report(input logic [7:0] tag, input logic [31:0] val, input int b,
                            input bit fr_on, input int extra_k, input int rst_k);
    fr_len   = b;
    fr_en    = fr_on;
    r_req_k  = -1;
    r_done_k = -1;
    txreq0   = n_txreq;
    @(posedge sys_clk); #2;
    bus.rpt_tag   = tag;
    bus.rpt_value = val;
    bus.rpt_req   = 1'b1;
    m_str    = $sformatf("%c=%0d\r\n", tag, val);
    m_base   = cyc;
    m_done_k = fr_on ? (REQ_K + 2 + b) : (REQ_K + TMO + 1);
    m_err    = !fr_on;
    m_active = 1'b1;
    @(posedge sys_clk); #2;
    bus.rpt_req   = 1'b0;
    bus.rpt_tag   = 8'h3F;
    bus.rpt_value = $urandom;
    if (extra_k > 0) begin
      while (cyc - m_base < extra_k) begin @(posedge sys_clk); #2; end
      bus.rpt_tag   = 8'h5A;
      bus.rpt_value = 32'd999;
      bus.rpt_req   = 1'b1;
      @(posedge sys_clk); #2;
      bus.rpt_req   = 1'b0;
    end
    if (rst_k > 0) begin
      while (cyc - m_base < rst_k) begin @(posedge sys_clk); #2; end
      sys_rst_n = 1'b0;
      m_active  = 1'b0;
      m_vis     = "";
      m_vis_err = 1'b0;
      #1;
      chk("mid_rst_busy", bus.rpt_busy, 0);
      chk("mid_rst_done", bus.rpt_done, 0);
      chk("mid_rst_err", bus.rpt_err, 0);
      chk("mid_rst_tx_req", bus.tx_req, 0);
      chk("mid_rst_length", bus.tx_length, 0);
      chk_vec("mid_rst_string", bus.tx_string[FB-1:0], '0);
      repeat (3) @(posedge sys_clk);
      #2 sys_rst_n = 1'b1;
    end else begin
      for (int i = 0; i < 600 && m_active; i++) @(posedge sys_clk);
      if (m_active) begin
        n_cmp++;
        n_bad++;
        $display("FAIL report_completes: still active after 600 cycles, expected done");
        m_active = 1'b0;
      end
    end
    repeat (3) @(posedge sys_clk);
    #2;
  endtask

  initial begin
    bus.rpt_req   = 1'b0;
    bus.rpt_tag   = '0;
    bus.rpt_value = '0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_busy", bus.rpt_busy, 0);
    chk("rst_done", bus.rpt_done, 0);
    chk("rst_err", bus.rpt_err, 0);
    chk("rst_tx_req", bus.tx_req, 0);
    chk("rst_length", bus.tx_length, 0);
    chk_vec("rst_string", bus.tx_string[FB-1:0], '0);
    @(posedge sys_clk); #2;
    sys_rst_n = 1'b1;
    chk_en    = 1'b1;
    repeat (2) @(posedge sys_clk);

    // Nominal: F = 12345, framer busy for 200 cycles
    run_report("F", 32'd12345, 200, 1'b1, 0, 0);
    chk("nom_req_cyc", r_req_k, 43);
    chk("nom_done_cyc", r_done_k, 245);
    chk("nom_err", r_done_err, 0);
    chk("nom_length", bus.tx_length, 9);
    chk_vec("nom_bytes", bus.tx_string[FB-1:0], {40'h0, 72'h0A0D35343332313D46});
    chk("nom_txreq_count", n_txreq - txreq0, 1);

    // Zero value
    run_report("A", 32'd0, 3, 1'b1, 0, 0);
    chk("zero_length", bus.tx_length, 5);
    chk_vec("zero_bytes", bus.tx_string[FB-1:0], {72'h0, 40'h0A0D303D41});
    chk("zero_done_cyc", r_done_k, 48);

    // Maximum value, then a short value to prove the old digits are cleared
    run_report("X", 32'hFFFF_FFFF, 5, 1'b1, 0, 0);
    chk("max_length", bus.tx_length, 14);
    chk_vec("max_bytes", bus.tx_string[FB-1:0], 112'h0A0D353932373639343932343D58);
    run_report("X", 32'd7, 1, 1'b1, 0, 0);
    chk("seven_length", bus.tx_length, 5);
    chk_vec("seven_bytes", bus.tx_string[FB-1:0], {72'h0, 40'h0A0D373D58});

    // Second request while busy is dropped
    run_report("B", 32'd1000, 2, 1'b1, 20, 0);
    chk("busyreq_txreq_count", n_txreq - txreq0, 1);
    chk("busyreq_length", bus.tx_length, 8);

    // Framer never answers: timeout abort
    run_report("T", 32'd42, 0, 1'b0, 0, 0);
    chk("tmo_done_cyc", r_done_k, 60);
    chk("tmo_err", r_done_err, 1);
    repeat (20) @(posedge sys_clk);
    #2;
    chk("tmo_txreq_count", n_txreq - txreq0, 1);

    // Reset in the middle of conversion, then a normal report
    run_report("R", 32'd55, 2, 1'b1, 0, 25);
    chk("rst_txreq_count", n_txreq - txreq0, 0);
    run_report("N", 32'd31415, 4, 1'b1, 0, 0);
    chk("post_rst_req_cyc", r_req_k, 43);
    chk("post_rst_done_cyc", r_done_k, 49);
    chk("post_rst_length", bus.tx_length, 9);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_value_reporter.md
# uart_value_reporter

Upstream feeder for the `&&…&&` UART string framer. It takes a tagged 32-bit unsigned value, converts it to decimal ASCII with a sequential double-dabble, and packs it into the framer's wide string bus as `<tag>=<digits>\r\n`. It then issues one transmit request and tracks the framer's busy signal until the frame has gone out. It is used to report measurement results (frequency, count, period) to the host.

## Interface
Parameters:
- `STR_BITS`, 1096: width of the framer string bus.
- `TIMEOUT_CYC`, 16: maximum number of cycles to wait for `tx_busy` to rise after `tx_req`.

Ports:
- `sys_clk`  in  1  system clock. This is the single clock domain.
- `sys_rst_n`  in  1  asynchronous, active-low reset.
- `rpt_req`  in  1  one-cycle start pulse. Sampled only in IDLE.
- `rpt_tag`  in  8  ASCII tag character. Latched on an accepted `rpt_req`.
- `rpt_value`  in  32  unsigned value. Latched on an accepted `rpt_req`.
- `rpt_busy`  out  1  high in every state except IDLE.
- `rpt_done`  out  1  one-cycle pulse when the report completes or aborts.
- `rpt_err`  out  1  valid with `rpt_done`. 1 means the report aborted on timeout.
- `tx_string`  out  STR_BITS  byte k is `[8k+7:8k]`. Byte 0 is transmitted first.
- `tx_length`  out  8  number of valid bytes in `tx_string`.
- `tx_req`  out  1  one-cycle request to the framer.
- `tx_busy`  in  1  framer busy flag.

## Operation
- **Reset values:** all outputs are 0, `tx_string` is all-zero, and the state is IDLE.
- **State machine (one-hot):** IDLE → CONV → PACK → SEND → WAIT_HI → WAIT_LO → DONE → IDLE.
- **IDLE:** when `rpt_req`=1, latch the tag and value, clear the BCD register, clear the conversion counter, and go to CONV.
- **CONV:** runs for 32 cycles. Each cycle applies add-3 to every BCD nibble ≥5, then shifts the BCD and binary registers left by one as a 72-bit concatenation (40-bit BCD with 10 nibbles, plus 32-bit binary). After 32 cycles, go to PACK.
- **PACK:** runs for 10 cycles and scans the nibbles from most significant to least significant, one per cycle.
  - Leading zeros are suppressed. The least significant nibble is always emitted, so a value of 0 produces "0".
  - Each emitted digit is written as `8'h30 + nibble` at byte index `2 + ndig`, and `ndig` is then incremented.
- **End of PACK:** write the following bytes:
  - byte 0 = tag
  - byte 1 = "="
  - byte `2+ndig` = 8'h0D
  - byte `3+ndig` = 8'h0A
  
  Set `tx_length = ndig + 4`, which ranges from 5 to 14. All bytes at or above `tx_length` are 0; `tx_string` is cleared on entry to CONV.
- **SEND:** `tx_req`=1 for exactly one cycle, then go to WAIT_HI.
- **WAIT_HI:**
  - If `tx_busy`=1, go to WAIT_LO.
  - If `TIMEOUT_CYC` cycles elapse without `tx_busy`, go to DONE with `rpt_err`=1.
- **WAIT_LO:** when `tx_busy`=0, go to DONE with `rpt_err`=0. There is no timeout in this state.
- **DONE:** `rpt_done`=1 for one cycle, then go to IDLE. `rpt_err` holds until the next accepted `rpt_req`.
- **Output stability:**
  - `tx_string` and `tx_length` are stable from SEND until the next accepted `rpt_req`.
  - `tx_length` is 0 after reset until the first report.
- **Requests while busy:** `rpt_req` outside IDLE is ignored and is not queued.
- **Input changes:** changes to `rpt_tag` or `rpt_value` after acceptance have no effect.
- **Reset mid-operation:** the block returns immediately to the reset values. No `tx_req` is generated for a report that was in progress.

## Timing
- Let the `rpt_req` edge be cycle 0.
  - CONV spans cycles 1–32.
  - PACK spans cycles 33–42.
  - `tx_req` is high in cycle 43.
- `rpt_busy` rises in cycle 1.
- `rpt_done` is asserted one cycle after the WAIT_LO exit condition is met. On timeout, it is asserted at cycle 43 + `TIMEOUT_CYC` + 1.
- After `rpt_done`, the earliest next acceptance is 1 cycle later, in IDLE.
- The framer raises `tx_busy` one cycle after `tx_req`, so in normal operation WAIT_HI lasts 1–2 cycles.

## Structure
- **Shared package `uart_report_pkg`:**
  - state one-hot localparams
  - ASCII constants (0x30, "=", CR, LF)
  - `MAX_DIGITS`=10
  - `MAX_FRAME_BYTES`=14
- **Sub-module `bin2bcd_seq`:** the iterative double-dabble converter.
  - Ports: `start`, `bin[31:0]`, `bcd[39:0]`, `done`.
  - The `done` pulse occurs 32 cycles after `start`.
- **Top level:** owns the state machine, the PACK index counter, the digit counter, and the timeout counter.

## Test plan
- **Nominal value:** tag "F", value 12345, framer modelled with busy for 200 cycles. Expect bytes "F=12345\r\n", `tx_length`=9, `tx_req` at cycle 43, and `rpt_done` with `rpt_err`=0 after busy falls.
- **Zero:** tag "A", value 0. Expect "A=0\r\n", `tx_length`=5, and bytes 5 and above all 0.
- **Maximum value:** value 4294967295. Expect "X=4294967295\r\n" and `tx_length`=14. Follow with value 7 and check that bytes 5–13 are cleared to 0.
- **Request while busy:** pulse `rpt_req` again in cycle 20 with value 999. Expect exactly one `tx_req` and the first value transmitted.
- **Timeout:** hold `tx_busy` at 0. Expect `rpt_done` with `rpt_err`=1 at cycle 60 (with `TIMEOUT_CYC`=16) and no second `tx_req`.
- **Reset mid-operation:** assert `sys_rst_n`=0 in cycle 25. Expect all outputs to be 0 immediately and no `tx_req`. After release, a new request operates normally.
